// File: rtl/reg_dump_uart.sv
// Walks the register-file debug select over registers 0..31 and streams each value
// as 8 uppercase hex characters plus a line feed on a UART 8N1 line.
//
// state | meaning
// IDLE  | line high, waiting for start
// SEL   | drive dbg_sel for one cycle, capture dbg_data into word
// START | start bit (low)
// DATA  | 8 data bits of the current character, LSB first
// STOP  | stop bit (high), then next character / next register / done
module reg_dump_uart #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] dbg_data,
    output logic [4:0]  dbg_sel,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        SEL,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    state_t      state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [3:0]  char_q, char_d;
    logic [4:0]  reg_q, reg_d;
    logic [31:0] word_q, word_d;
    logic        done_q, done_d;

    logic        baud_last;
    logic [7:0]  cur_char;

    // char index 0..7 selects a nibble from the MSB down; index 8 is the line feed
    function automatic logic [7:0] hex_char(input logic [31:0] w, input logic [3:0] idx);
        logic [31:0] sh;
        logic [3:0]  nib;
        sh  = w << {idx[2:0], 2'b00};
        nib = sh[31:28];
        if (idx == 4'd8)
            hex_char = 8'h0A;
        else if (nib < 4'd10)
            hex_char = 8'h30 + {4'h0, nib};
        else
            hex_char = 8'h37 + {4'h0, nib};
    endfunction

    assign baud_last = (baud_q == BAUD_LAST);
    assign cur_char  = hex_char(word_q, char_q);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            char_q  <= '0;
            reg_q   <= '0;
            word_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            char_q  <= char_d;
            reg_q   <= reg_d;
            word_q  <= word_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        char_d  = char_q;
        reg_d   = reg_q;
        word_d  = word_q;
        done_d  = 1'b0;
        tx      = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SEL;
                    reg_d   = '0;
                end
            end
            SEL: begin
                word_d  = dbg_data;
                char_d  = '0;
                baud_d  = '0;
                state_d = START;
            end
            START: begin
                tx = 1'b0;
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            DATA: begin
                tx = cur_char[bit_q];
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (char_q != 4'd8) begin
                        char_d  = char_q + 4'd1;
                        state_d = START;
                    end else if (reg_q != 5'd31) begin
                        reg_d   = reg_q + 5'd1;
                        state_d = SEL;
                    end else begin
                        // leave every counter at zero so IDLE matches the reset picture
                        char_d  = '0;
                        reg_d   = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dbg_sel = (state_q == IDLE) ? 5'd0 : reg_q;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;

endmodule

// File: tb/tb_reg_dump_uart.sv
// Scoreboarded bench for reg_dump_uart: a register model feeds dbg_data, a UART
// receiver decodes tx and compares each byte against the expected stream.
module tb_reg_dump_uart;

    localparam int C        = 4;
    localparam int REG_CYC  = 1 + 90 * C;
    localparam int DUMP_CYC = 32 * REG_CYC;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] dbg_data;
    logic [4:0]  dbg_sel;
    logic        tx;
    logic        busy;
    logic        done;

    logic [31:0] regs [32];
    logic [7:0]  exp_q [$];
    bit          sb_on = 1'b0;
    int          n_total = 0;
    int          n_bad = 0;
    int          rx_cnt = 0;
    string       hexs = "0123456789ABCDEF";
    logic [7:0]  rx_b;
    logic        rx_stop;
    logic [7:0]  rx_exp;

    always #5 clk = ~clk;

    assign dbg_data = regs[dbg_sel];

    reg_dump_uart #(.CLKS_PER_BIT(C)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .dbg_data (dbg_data),
        .dbg_sel  (dbg_sel),
        .tx       (tx),
        .busy     (busy),
        .done     (done)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_dump;
        for (int r = 0; r < 32; r++) begin
            for (int k = 0; k < 8; k++) begin
                logic [3:0] n;
                n = regs[r][31 - 4 * k -: 4];
                exp_q.push_back(8'(hexs.getc(int'(n))));
            end
            exp_q.push_back(8'h0A);
        end
    endtask

    // entered during the SEL cycle of register 0; returns in the first IDLE cycle
    task automatic wait_dump(input string tag, input int mode, input bit flip3);
        int cyc = 0;
        int busy_cnt = 0;
        int done_cnt = 0;
        int chg = 0;
        int bad_step = 0;
        int bad_int = 0;
        int bad_gap = 0;
        int last = 0;
        logic [4:0] prev = 5'd0;
        while (busy === 1'b1 && cyc < 3 * DUMP_CYC) begin
            busy_cnt++;
            if (done !== 1'b0) done_cnt++;
            if (cyc == 1) check_eq({tag, "_txfall"}, {31'd0, tx}, 32'd0);
            if (dbg_sel !== prev) begin
                chg++;
                if (dbg_sel !== prev + 5'd1) bad_step++;
                if (cyc - last != REG_CYC) bad_int++;
                if (tx !== 1'b1) bad_gap++;
                prev = dbg_sel;
                last = cyc;
            end
            if (mode == 1) start = (cyc == 100 || cyc == 5000);
            if (flip3 && cyc == 3 * REG_CYC + 50) regs[3] = 32'hFFFF_FFFF;
            tick;
            cyc++;
        end
        check_eq({tag, "_busy_len"}, busy_cnt, DUMP_CYC);
        check_eq({tag, "_done_early"}, done_cnt, 0);
        check_eq({tag, "_sel_steps"}, chg, 31);
        check_eq({tag, "_sel_order"}, bad_step, 0);
        check_eq({tag, "_sel_interval"}, bad_int, 0);
        check_eq({tag, "_sel_gap_tx"}, bad_gap, 0);
        check_eq({tag, "_done_pulse"}, {31'd0, done}, 32'd1);
        check_eq({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    endtask

    // UART receiver: samples near the middle of each bit, all on posedge+1 timing
    initial begin
        forever begin
            tick;
            if (tx === 1'b0) begin
                repeat (2) tick;
                for (int i = 0; i < 8; i++) begin
                    repeat (C) tick;
                    rx_b[i] = tx;
                end
                repeat (C) tick;
                rx_stop = tx;
                if (sb_on) begin
                    rx_cnt++;
                    check_eq("rx_have_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                    if (exp_q.size() != 0) begin
                        rx_exp = exp_q.pop_front();
                        check_eq("rx_byte", {24'd0, rx_b}, {24'd0, rx_exp});
                    end
                    check_eq("rx_stop", {31'd0, rx_stop}, 32'd1);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;

        repeat (3) tick;
        check_eq("rst_tx", {31'd0, tx}, 32'd1);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_sel", {27'd0, dbg_sel}, 32'd0);
        reset_n = 1'b1;
        tick;

        // abort a dump mid-character with reset
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (30) tick;
        check_eq("pre_rst_busy", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick;
            check_eq("abort_tx", {31'd0, tx}, 32'd1);
            check_eq("abort_busy", {31'd0, busy}, 32'd0);
            check_eq("abort_sel", {27'd0, dbg_sel}, 32'd0);
            check_eq("abort_done", {31'd0, done}, 32'd0);
        end
        reset_n = 1'b1;
        repeat (50) tick;

        // dump A: pattern registers, dbg_data flips mid-register 3, start pulses ignored
        regs[5] = 32'hDEAD_BEEF;
        regs[3] = 32'h1234_5678;
        sb_on = 1'b1;
        rx_cnt = 0;
        push_dump;
        start = 1'b1;
        tick;
        start = 1'b0;
        check_eq("a_sel_busy", {31'd0, busy}, 32'd1);
        check_eq("a_sel_idx", {27'd0, dbg_sel}, 32'd0);
        check_eq("a_sel_tx", {31'd0, tx}, 32'd1);
        wait_dump("a", 1, 1'b1);
        tick;
        check_eq("a_done_one_cycle", {31'd0, done}, 32'd0);
        check_eq("a_no_queued_start", {31'd0, busy}, 32'd0);
        repeat (5) tick;
        check_eq("a_sb_left", exp_q.size(), 0);
        check_eq("a_rx_count", rx_cnt, 288);

        // dump B: start held high, second dump follows the done cycle
        regs[3]  = 32'h1234_5678;
        regs[31] = 32'hA5F0_C3E9;
        rx_cnt = 0;
        push_dump;
        push_dump;
        start = 1'b1;
        tick;
        check_eq("b1_sel_busy", {31'd0, busy}, 32'd1);
        wait_dump("b1", 0, 1'b0);
        tick;
        check_eq("b_restart_done", {31'd0, done}, 32'd0);
        check_eq("b_restart_busy", {31'd0, busy}, 32'd1);
        check_eq("b_restart_sel", {27'd0, dbg_sel}, 32'd0);
        check_eq("b_restart_tx", {31'd0, tx}, 32'd1);
        start = 1'b0;
        wait_dump("b2", 0, 1'b0);
        repeat (5) tick;
        check_eq("b_sb_left", exp_q.size(), 0);
        check_eq("b_rx_count", rx_cnt, 576);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
